// File: rtl/sys1_video_timing.sv
// sys1_video_timing: pixel-enable, raster counters, sync/blank generation and RGB expansion
// Ports:
//    clk48M, reset        master clock, async active-high reset
//    HOFS, VOFS           signed sync shifts (pixels / lines), latched at frame start
//    POUT                 core pixel {B[1:0],G[2:0],R[2:0]}
//    CE_PIX               6 MHz pixel enable, one clk48M in eight
//    PH, PV               raster position presented to the core this pixel
//    R, G, B              expanded colour, aligned with the sync/blank outputs
//    HSYNC, VSYNC         active-high syncs
//    HBLANK, VBLANK, DE   active-high blanks and display enable
module sys1_video_timing #(
   parameter int HTOTAL   = 384,
   parameter int HACT     = 256,
   parameter int HS_START = 304,
   parameter int HS_WIDTH = 32,
   parameter int VTOTAL   = 264,
   parameter int VACT     = 224,
   parameter int VS_START = 236,
   parameter int VS_WIDTH = 3
) (
   input  logic       clk48M,
   input  logic       reset,
   input  logic [3:0] HOFS,
   input  logic [3:0] VOFS,
   input  logic [7:0] POUT,
   output logic       CE_PIX,
   output logic [8:0] PH,
   output logic [8:0] PV,
   output logic [7:0] R,
   output logic [7:0] G,
   output logic [7:0] B,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       HBLANK,
   output logic       VBLANK,
   output logic       DE
);
   localparam logic signed [9:0] HS_MIN = 10'(HACT);
   localparam logic signed [9:0] HS_MAX = 10'(HTOTAL - HS_WIDTH);
   localparam logic signed [9:0] VS_MIN = 10'(VACT);
   localparam logic signed [9:0] VS_MAX = 10'(VTOTAL - VS_WIDTH);

   logic [2:0] div_q, div_d;
   logic       ce_q, ce_d;
   logic [8:0] ph_q, ph_d, pv_q, pv_d;
   logic [3:0] hofs_q, hofs_d, vofs_q, vofs_d;
   logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic       hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d, de_q, de_d;
   logic signed [9:0] hs_raw, vs_raw, hs_pos, vs_pos;
   logic       ph_wrap, pv_wrap, hb0, vb0, hs0, vs0;

   // offsets are held in registers so a mid-frame change cannot tear the raster
   assign hs_raw  = 10'(HS_START) + {{6{hofs_q[3]}}, hofs_q};
   assign vs_raw  = 10'(VS_START) + {{6{vofs_q[3]}}, vofs_q};
   assign hs_pos  = hs_raw < HS_MIN ? HS_MIN : hs_raw > HS_MAX ? HS_MAX : hs_raw;
   assign vs_pos  = vs_raw < VS_MIN ? VS_MIN : vs_raw > VS_MAX ? VS_MAX : vs_raw;
   assign ph_wrap = ph_q == 9'(HTOTAL - 1);
   assign pv_wrap = pv_q == 9'(VTOTAL - 1);
   assign hb0     = ph_q >= 9'(HACT);
   assign vb0     = pv_q >= 9'(VACT);
   assign hs0     = {1'b0, ph_q} >= hs_pos && {1'b0, ph_q} < hs_pos + 10'(HS_WIDTH);
   assign vs0     = {1'b0, pv_q} >= vs_pos && {1'b0, pv_q} < vs_pos + 10'(VS_WIDTH);

   always_comb begin
      div_d  = div_q + 3'd1;
      ce_d   = div_q == 3'd7;
      ph_d   = ph_q;
      pv_d   = pv_q;
      hofs_d = hofs_q;
      vofs_d = vofs_q;
      r_d    = r_q;
      g_d    = g_q;
      b_d    = b_q;
      hs_d   = hs_q;
      vs_d   = vs_q;
      hb_d   = hb_q;
      vb_d   = vb_q;
      de_d   = de_q;
      if (ce_q) begin
         ph_d   = ph_wrap ? 9'd0 : ph_q + 9'd1;
         pv_d   = !ph_wrap ? pv_q : pv_wrap ? 9'd0 : pv_q + 9'd1;
         hofs_d = (ph_q == 9'd0 && pv_q == 9'd0) ? HOFS : hofs_q;
         vofs_d = (ph_q == 9'd0 && pv_q == 9'd0) ? VOFS : vofs_q;
         r_d    = (hb0 || vb0) ? 8'd0 : {POUT[2:0], POUT[2:0], POUT[2:1]};
         g_d    = (hb0 || vb0) ? 8'd0 : {POUT[5:3], POUT[5:3], POUT[5:4]};
         b_d    = (hb0 || vb0) ? 8'd0 : {4{POUT[7:6]}};
         hs_d   = hs0;
         vs_d   = vs0;
         hb_d   = hb0;
         vb_d   = vb0;
         de_d   = !(hb0 || vb0);
      end
   end

   always_ff @(posedge clk48M or posedge reset) begin
      if (reset) begin
         div_q  <= 3'd0;
         ce_q   <= 1'b0;
         ph_q   <= 9'd0;
         pv_q   <= 9'd0;
         hofs_q <= 4'd0;
         vofs_q <= 4'd0;
         r_q    <= 8'd0;
         g_q    <= 8'd0;
         b_q    <= 8'd0;
         hs_q   <= 1'b0;
         vs_q   <= 1'b0;
         hb_q   <= 1'b1;
         vb_q   <= 1'b1;
         de_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         ce_q   <= ce_d;
         ph_q   <= ph_d;
         pv_q   <= pv_d;
         hofs_q <= hofs_d;
         vofs_q <= vofs_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         hb_q   <= hb_d;
         vb_q   <= vb_d;
         de_q   <= de_d;
      end
   end

   assign CE_PIX = ce_q;
   assign PH     = ph_q;
   assign PV     = pv_q;
   assign R      = r_q;
   assign G      = g_q;
   assign B      = b_q;
   assign HSYNC  = hs_q;
   assign VSYNC  = vs_q;
   assign HBLANK = hb_q;
   assign VBLANK = vb_q;
   assign DE     = de_q;
endmodule

// File: tb/tb_sys1_video_timing.sv
// tb_sys1_video_timing: directed scoreboard bench on a reduced 40x12 raster
module tb_sys1_video_timing;
   localparam int HT = 40, HA = 16, HSS = 30, HSW = 4;
   localparam int VT = 12, VA = 8, VSS = 9, VSW = 2;

   logic       clk48M = 1'b0;
   logic       reset;
   logic [3:0] HOFS, VOFS;
   logic [7:0] POUT;
   logic       CE_PIX;
   logic [8:0] PH, PV;
   logic [7:0] R, G, B;
   logic       HSYNC, VSYNC, HBLANK, VBLANK, DE;

   sys1_video_timing #(
      .HTOTAL(HT), .HACT(HA), .HS_START(HSS), .HS_WIDTH(HSW),
      .VTOTAL(VT), .VACT(VA), .VS_START(VSS), .VS_WIDTH(VSW)
   ) dut (
      .clk48M(clk48M), .reset(reset), .HOFS(HOFS), .VOFS(VOFS), .POUT(POUT),
      .CE_PIX(CE_PIX), .PH(PH), .PV(PV), .R(R), .G(G), .B(B),
      .HSYNC(HSYNC), .VSYNC(VSYNC), .HBLANK(HBLANK), .VBLANK(VBLANK), .DE(DE)
   );

   always #5 clk48M = ~clk48M;

   // fl = {HSYNC, VSYNC, HBLANK, VBLANK, DE}
   typedef struct {
      int         f, ph, pv;
      logic [7:0] pout, r, g, b;
      logic [4:0] fl;
   } vec_t;

   vec_t vec[$];
   vec_t q[$];
   vec_t e;
   int   checks = 0, failures = 0;
   int   f = 0, mph = 0, mpv = 0, vi = 0, n;
   bit   pend = 0;
   int   mon_ph = 0, mon_pv = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic add(input int vf, vph, vpv, input logic [7:0] vp, vr, vg, vb, input logic [4:0] vfl);
      vec_t v;
      v.f = vf; v.ph = vph; v.pv = vpv; v.pout = vp;
      v.r = vr; v.g = vg; v.b = vb; v.fl = vfl;
      vec.push_back(v);
   endtask

   task automatic chk_reset();
      chk("rst_PH_PV", {PH, PV}, 0);
      chk("rst_RGB", {R, G, B}, 0);
      chk("rst_flags", {CE_PIX, HSYNC, VSYNC, HBLANK, VBLANK, DE}, 6'b000110);
   endtask

   task automatic wait_ce(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk48M);
         cnt++;
      end while (!CE_PIX && cnt < 32);
      if (!CE_PIX) begin
         failures++;
         $display("FAIL ce_timeout got=none want=CE_PIX within 32 clocks");
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   endtask

   // called on the negedge where CE_PIX is high: the DUT presents (mph,mpv) now
   task automatic handle();
      POUT = 8'h00;
      if (vi < vec.size() && vec[vi].f == f && vec[vi].ph == mph && vec[vi].pv == mpv) begin
         POUT = vec[vi].pout;
         q.push_back(vec[vi]);
         vi++;
      end
      if (f == 0 && mph == 0 && mpv == 2) begin HOFS = 4'b1000; VOFS = 4'b1000; end
      if (f == 1 && mph == 0 && mpv == 2) begin HOFS = 4'd7; VOFS = 4'd0; end
      mph++;
      if (mph == HT) begin
         mph = 0;
         mpv++;
         if (mpv == VT) begin mpv = 0; f++; end
      end
   endtask

   always @(negedge clk48M) begin
      #1;
      if (reset) begin
         pend = 0;
         mon_ph = 0;
         mon_pv = 0;
      end else begin
         if (pend) begin
            if (q.size() > 0 && q[0].ph == mon_ph && q[0].pv == mon_pv) begin
               e = q.pop_front();
               chk($sformatf("rgb@%0d,%0d", e.ph, e.pv), {R, G, B}, {e.r, e.g, e.b});
               chk($sformatf("hs_vs_hb_vb_de@%0d,%0d", e.ph, e.pv),
                   {HSYNC, VSYNC, HBLANK, VBLANK, DE}, e.fl);
            end
            mon_ph++;
            if (mon_ph == HT) begin
               mon_ph = 0;
               mon_pv++;
               if (mon_pv == VT) mon_pv = 0;
            end
            pend = 0;
         end
         if (CE_PIX) begin
            if (q.size() > 0 && q[0].ph == mon_ph && q[0].pv == mon_pv)
               chk($sformatf("ph_pv@%0d,%0d", mon_ph, mon_pv), {PH, PV}, {9'(q[0].ph), 9'(q[0].pv)});
            pend = 1;
         end
      end
   end

   initial begin
      reset = 1'b1; POUT = 8'h00; HOFS = 4'd0; VOFS = 4'd0;
      // frame 0: nominal hs=30..33, vs lines 9..10
      add(0, 10, 2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'b00001);
      add(0, 11, 2, 8'h55, 8'hB6, 8'h49, 8'h55, 5'b00001);
      add(0, 15, 2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'b00001);
      add(0, 16, 2, 8'hFF, 8'h00, 8'h00, 8'h00, 5'b00100);
      add(0, 29, 3, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00100);
      add(0, 30, 3, 8'h00, 8'h00, 8'h00, 8'h00, 5'b10100);
      add(0, 33, 3, 8'h00, 8'h00, 8'h00, 8'h00, 5'b10100);
      add(0, 34, 3, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00100);
      add(0,  5, 7, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'b00001);
      add(0,  5, 8, 8'hFF, 8'h00, 8'h00, 8'h00, 5'b00010);
      add(0,  0, 9, 8'h00, 8'h00, 8'h00, 8'h00, 5'b01010);
      add(0, 39, 10, 8'h00, 8'h00, 8'h00, 8'h00, 5'b01110);
      add(0,  0, 11, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00010);
      add(0, 39, 11, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00110);
      // frame 1: HOFS=-8 -> hs=22..25, VOFS=-8 clamps to vs lines 8..9
      add(1,  0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'b00001);
      add(1, 21, 1, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00100);
      add(1, 22, 1, 8'h00, 8'h00, 8'h00, 8'h00, 5'b10100);
      add(1, 25, 1, 8'h00, 8'h00, 8'h00, 8'h00, 5'b10100);
      add(1, 26, 1, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00100);
      add(1, 22, 3, 8'h00, 8'h00, 8'h00, 8'h00, 5'b10100);
      add(1,  0, 7, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00001);
      add(1,  0, 8, 8'h00, 8'h00, 8'h00, 8'h00, 5'b01010);
      add(1,  0, 10, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00010);
      // frame 2: HOFS=+7 clamps to hs=36..39, VOFS=0 -> vs lines 9..10
      add(2, 35, 1, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00100);
      add(2, 36, 1, 8'h00, 8'h00, 8'h00, 8'h00, 5'b10100);
      add(2, 39, 1, 8'h00, 8'h00, 8'h00, 8'h00, 5'b10100);
      add(2,  0, 8, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00010);
      add(2,  0, 9, 8'h00, 8'h00, 8'h00, 8'h00, 5'b01010);
      add(3, 10, 2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'b00001);
      // after the mid-line reset, counting restarts at 0,0
      add(0,  0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'b00001);
      add(0,  1, 0, 8'h55, 8'hB6, 8'h49, 8'h55, 5'b00001);

      #3 chk_reset();
      repeat (3) @(negedge clk48M);
      reset = 1'b0;
      wait_ce(n);
      chk("first_ce_clocks", n, 8);
      handle();
      wait_ce(n);
      chk("ce_period", n, 8);
      handle();
      @(negedge clk48M);
      chk("ce_duty", CE_PIX, 0);
      while (!(f == 3 && mpv == 2 && mph == 11)) begin
         wait_ce(n);
         handle();
      end
      @(negedge clk48M);
      #3;
      chk("queue_drained_pre_reset", q.size(), 0);
      chk("pre_reset_PH", PH, 11);
      reset = 1'b1;
      #1 chk_reset();
      q.delete();
      f = 0; mph = 0; mpv = 0;
      repeat (2) @(negedge clk48M);
      reset = 1'b0;
      wait_ce(n);
      chk("first_ce_after_reset", n, 8);
      handle();
      repeat (2) begin
         wait_ce(n);
         handle();
      end
      repeat (3) @(negedge clk48M);
      #2;
      chk("queue_drained_end", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
